// File: rtl/ysyx_25040111_lsu_store_if.sv
// Handshake bundles for the store executor.
// req_if : EXU/LSU request + completion (master = issuer, slave = store executor).
// axi_if : AXI4-Lite write channels AW/W/B (master = store executor, slave = memory).
interface ysyx_25040111_lsu_store_req_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        resp_valid;
  logic        resp_ready;
  logic        resp_err;
  logic [1:0]  resp_code;

  modport master (
    output req_valid, req_addr, req_data, req_size, resp_ready,
    input  req_ready, resp_valid, resp_err, resp_code
  );
  modport slave (
    input  req_valid, req_addr, req_data, req_size, resp_ready,
    output req_ready, resp_valid, resp_err, resp_code
  );
endinterface

interface ysyx_25040111_lsu_store_axi_if;
  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        bvalid;
  logic        bready;
  logic [1:0]  bresp;

  modport master (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready,
    input  awready, wready, bvalid, bresp
  );
  modport slave (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready,
    output awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/ysyx_25040111_lsu_store.sv
// Store executor: one sb/sh/sw request -> one AXI4-Lite write (AW, W, B) -> one response.
// Latency: zero-wait slave gives resp_valid 3 cycles after accept; illegal request 1 cycle.
// Backpressure: req_ready only in IDLE; AW/W valids held until their own handshake; resp held until resp_ready.
// Ports: clk, rst (sync, active-high); req (slave side of req_if); axi (master side of axi_if).
module ysyx_25040111_lsu_store #(
  parameter int unsigned TIMEOUT = 255  // cycles allowed in SEND+WAIT_B; 0 disables
) (
  input  logic                                 clk,
  input  logic                                 rst,
  ysyx_25040111_lsu_store_req_if.slave  req,
  ysyx_25040111_lsu_store_axi_if.master axi
);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT_B, S_RESP} state_t;

  localparam int unsigned   CW      = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  localparam bit            TO_EN   = (TIMEOUT != 0);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_req_ready;
  logic          r_resp_valid;
  logic          r_resp_err;
  logic [1:0]    r_resp_code;
  logic          r_awvalid;
  logic          r_wvalid;
  logic          r_bready;
  logic [31:0]   r_awaddr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;

  logic          w_legal;
  logic [31:0]   w_wdata;
  logic [3:0]    w_wstrb;
  logic          w_timeout;
  logic          w_aw_left;
  logic          w_w_left;
  logic          w_unused;

  // Only bresp[1] distinguishes OKAY/EXOKAY from SLVERR/DECERR.
  assign w_unused = axi.bresp[0];

  // Lane replication and strobe from the request size and byte offset.
  always_comb begin
    w_legal = 1'b0;
    w_wdata = req.req_data;
    w_wstrb = 4'b0000;
    case (req.req_size)
      2'b00: begin
        w_legal = 1'b1;
        w_wdata = {4{req.req_data[7:0]}};
        w_wstrb = 4'b0001 << req.req_addr[1:0];
      end
      2'b01: begin
        w_legal = ~req.req_addr[0];
        w_wdata = {2{req.req_data[15:0]}};
        w_wstrb = 4'b0011 << req.req_addr[1:0];
      end
      2'b10: begin
        w_legal = (req.req_addr[1:0] == 2'b00);
        w_wdata = req.req_data;
        w_wstrb = 4'b1111;
      end
      default: w_legal = 1'b0;
    endcase
  end

  // The count covers every cycle spent in SEND/WAIT_B; the cycle where it
  // sits on TIMEOUT-1 is the last one allowed.
  assign w_timeout = TO_EN && (r_cnt == TO_LAST);
  // A channel is still outstanding if its valid is up and this edge does not complete it.
  assign w_aw_left = r_awvalid & ~axi.awready;
  assign w_w_left  = r_wvalid  & ~axi.wready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_code  <= 2'b00;
      r_awvalid    <= 1'b0;
      r_wvalid     <= 1'b0;
      r_bready     <= 1'b0;
      r_awaddr     <= '0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req.req_valid) begin
            r_req_ready <= 1'b0;
            if (w_legal) begin
              r_state   <= S_SEND;
              r_cnt     <= '0;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_awaddr  <= {req.req_addr[31:2], 2'b00};
              r_wdata   <= w_wdata;
              r_wstrb   <= w_wstrb;
            end else begin
              r_state      <= S_RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= 1'b1;
              r_resp_code  <= 2'b01;
            end
          end
        end
        S_SEND: begin
          r_awvalid <= w_aw_left;
          r_wvalid  <= w_w_left;
          if (w_timeout) begin
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_code  <= 2'b11;
          end else begin
            r_cnt <= r_cnt + 1'b1;
            if (!w_aw_left && !w_w_left) begin
              r_state  <= S_WAIT_B;
              r_bready <= 1'b1;
            end
          end
        end
        S_WAIT_B: begin
          // A B response on the final allowed cycle takes precedence over the timeout.
          if (axi.bvalid) begin
            r_bready     <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= axi.bresp[1];
            r_resp_code  <= axi.bresp[1] ? 2'b10 : 2'b00;
          end else if (w_timeout) begin
            r_bready     <= 1'b0;
            r_state      <= S_RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= 1'b1;
            r_resp_code  <= 2'b11;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_RESP: begin
          if (req.resp_ready) begin
            r_state      <= S_IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_code  <= 2'b00;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req.req_ready  = r_req_ready;
  assign req.resp_valid = r_resp_valid;
  assign req.resp_err   = r_resp_err;
  assign req.resp_code  = r_resp_code;
  assign axi.awvalid    = r_awvalid;
  assign axi.awaddr     = r_awaddr;
  assign axi.wvalid     = r_wvalid;
  assign axi.wdata      = r_wdata;
  assign axi.wstrb      = r_wstrb;
  assign axi.bready     = r_bready;

endmodule

// File: tb/tb_ysyx_25040111_lsu_store.sv
module tb_ysyx_25040111_lsu_store;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ysyx_25040111_lsu_store_req_if req_if ();
  ysyx_25040111_lsu_store_axi_if axi_if ();
  ysyx_25040111_lsu_store_req_if to_req_if ();
  ysyx_25040111_lsu_store_axi_if to_axi_if ();

  ysyx_25040111_lsu_store #(.TIMEOUT(255)) dut (
    .clk (clk),
    .rst (rst),
    .req (req_if),
    .axi (axi_if)
  );

  // Second instance with a short timeout, attached to a slave that never answers B.
  ysyx_25040111_lsu_store #(.TIMEOUT(8)) dut_to (
    .clk (clk),
    .rst (rst),
    .req (to_req_if),
    .axi (to_axi_if)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave model with programmable delays ----------------
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
  logic [1:0]  cfg_bresp = 2'b00;
  bit          s_aw_done, s_w_done;
  int          s_aw_cnt, s_w_cnt, s_b_cnt;
  int          aw_hs = 0, w_hs = 0;
  logic [31:0] cap_awaddr, cap_wdata;
  logic [3:0]  cap_wstrb;

  // Decisions are made at the falling edge for the handshake on the next rising edge.
  initial begin
    axi_if.awready = 1'b0;
    axi_if.wready  = 1'b0;
    axi_if.bvalid  = 1'b0;
    axi_if.bresp   = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        s_aw_done = 0; s_w_done = 0;
        s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0;
        axi_if.awready = 1'b0;
        axi_if.wready  = 1'b0;
        axi_if.bvalid  = 1'b0;
      end else begin
        if (s_aw_done && s_w_done) begin
          axi_if.bvalid = (s_b_cnt >= cfg_b_dly);
          axi_if.bresp  = cfg_bresp;
          if (axi_if.bvalid && axi_if.bready) begin
            s_aw_done = 0; s_w_done = 0;
            s_aw_cnt = 0; s_w_cnt = 0; s_b_cnt = 0;
          end else begin
            s_b_cnt++;
          end
        end else begin
          axi_if.bvalid = 1'b0;
        end
        axi_if.awready = axi_if.awvalid && !s_aw_done && (s_aw_cnt >= cfg_aw_dly);
        if (axi_if.awvalid && !s_aw_done) begin
          if (axi_if.awready) begin
            s_aw_done = 1; cap_awaddr = axi_if.awaddr; aw_hs++;
          end else s_aw_cnt++;
        end
        axi_if.wready = axi_if.wvalid && !s_w_done && (s_w_cnt >= cfg_w_dly);
        if (axi_if.wvalid && !s_w_done) begin
          if (axi_if.wready) begin
            s_w_done = 1; cap_wdata = axi_if.wdata; cap_wstrb = axi_if.wstrb; w_hs++;
          end else s_w_cnt++;
        end
      end
    end
  end

  // ---------------- reference model ----------------
  // Byte lanes written: offset..offset+size-1; each lane carries data byte (lane mod size).
  function automatic void ref_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                                    output bit legal, output logic [31:0] ea,
                                    output logic [31:0] ew, output logic [3:0] es);
    int nb  = 1 << sz;
    int off = int'(a % 4);
    legal = (sz != 2'd3) && (a % nb == 0);
    ea = a - off;
    for (int i = 0; i < 4; i++) begin
      ew[8*i +: 8] = d[8*(i % nb) +: 8];
      es[i] = (i >= off) && (i < off + nb);
    end
  endfunction

  // ---------------- request-side helpers (called at a falling edge) ----------------
  task automatic send_req(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
    int k = 0;
    req_if.req_valid = 1'b1;
    req_if.req_addr  = a;
    req_if.req_data  = d;
    req_if.req_size  = sz;
    while (!req_if.req_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!req_if.req_ready) check("req_accept_wait", {31'd0, req_if.req_ready}, 32'd1);
    @(negedge clk);
    req_if.req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int lat);
    lat = 1;
    while (!req_if.resp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    if (!req_if.resp_valid) check("resp_wait", {31'd0, req_if.resp_valid}, 32'd1);
  endtask

  task automatic ack_resp();
    req_if.resp_ready = 1'b1;
    @(negedge clk);
    req_if.resp_ready = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  bresp;
    logic [1:0]  code;
    logic        err;
    logic        bus;
    logic [31:0] awaddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          lat;
  } vec_t;

  vec_t vt[12];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, a0, w0;
    bit legal;
    logic [31:0] ea, ew, ra, rd;
    logic [3:0] es;
    logic [1:0] rs, rb, ecode;

    vt[0]  = '{2'd0, 32'h8000_0003, 32'h1234_56AB, 2'd0, 2'd0, 1'b0, 1'b1, 32'h8000_0000, 32'hABAB_ABAB, 4'b1000, 3};
    vt[1]  = '{2'd1, 32'h8000_0002, 32'hDEAD_BEEF, 2'd0, 2'd0, 1'b0, 1'b1, 32'h8000_0000, 32'hBEEF_BEEF, 4'b1100, 3};
    vt[2]  = '{2'd1, 32'h8000_0001, 32'hDEAD_BEEF, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1};
    vt[3]  = '{2'd2, 32'h8000_0004, 32'hCAFE_F00D, 2'd0, 2'd0, 1'b0, 1'b1, 32'h8000_0004, 32'hCAFE_F00D, 4'b1111, 3};
    vt[4]  = '{2'd2, 32'h8000_0006, 32'h0102_0304, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1};
    vt[5]  = '{2'd3, 32'h8000_0000, 32'hFFFF_FFFF, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1};
    vt[6]  = '{2'd0, 32'h1000_0001, 32'h0000_00FF, 2'd0, 2'd0, 1'b0, 1'b1, 32'h1000_0000, 32'hFFFF_FFFF, 4'b0010, 3};
    vt[7]  = '{2'd1, 32'h2000_0000, 32'h1234_A55A, 2'd0, 2'd0, 1'b0, 1'b1, 32'h2000_0000, 32'hA55A_A55A, 4'b0011, 3};
    vt[8]  = '{2'd2, 32'h8000_0008, 32'h1122_3344, 2'd2, 2'd2, 1'b1, 1'b1, 32'h8000_0008, 32'h1122_3344, 4'b1111, 3};
    vt[9]  = '{2'd0, 32'h8000_0002, 32'h0000_0077, 2'd1, 2'd0, 1'b0, 1'b1, 32'h8000_0000, 32'h7777_7777, 4'b0100, 3};
    vt[10] = '{2'd1, 32'h8000_000E, 32'h0000_BEEF, 2'd3, 2'd2, 1'b1, 1'b1, 32'h8000_000C, 32'hBEEF_BEEF, 4'b1100, 3};
    vt[11] = '{2'd2, 32'h8000_0001, 32'h5555_5555, 2'd0, 2'd1, 1'b1, 1'b0, 32'h0, 32'h0, 4'b0000, 1};

    req_if.req_valid = 1'b0; req_if.req_addr = '0; req_if.req_data = '0;
    req_if.req_size = '0; req_if.resp_ready = 1'b0;
    to_req_if.req_valid = 1'b0; to_req_if.req_addr = '0; to_req_if.req_data = '0;
    to_req_if.req_size = '0; to_req_if.resp_ready = 1'b0;
    to_axi_if.awready = 1'b1; to_axi_if.wready = 1'b1;
    to_axi_if.bvalid = 1'b0; to_axi_if.bresp = 2'b00;

    // ---- reset values ----
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'd0, req_if.req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, req_if.resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, req_if.resp_err}, 32'd0);
    check("rst_resp_code", {30'd0, req_if.resp_code}, 32'd0);
    check("rst_awvalid", {31'd0, axi_if.awvalid}, 32'd0);
    check("rst_wvalid", {31'd0, axi_if.wvalid}, 32'd0);
    check("rst_bready", {31'd0, axi_if.bready}, 32'd0);
    check("rst_awaddr", axi_if.awaddr, 32'd0);
    check("rst_wdata", axi_if.wdata, 32'd0);
    check("rst_wstrb", {28'd0, axi_if.wstrb}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ---- table-driven vectors, zero-wait slave ----
    for (int i = 0; i < 12; i++) begin
      cfg_aw_dly = 0; cfg_w_dly = 0; cfg_b_dly = 0; cfg_bresp = vt[i].bresp;
      a0 = aw_hs; w0 = w_hs;
      send_req(vt[i].addr, vt[i].data, vt[i].sz);
      wait_resp(lat);
      check($sformatf("v%0d_code", i), {30'd0, req_if.resp_code}, {30'd0, vt[i].code});
      check($sformatf("v%0d_err", i), {31'd0, req_if.resp_err}, {31'd0, vt[i].err});
      check($sformatf("v%0d_latency", i), lat, vt[i].lat);
      check($sformatf("v%0d_req_ready_busy", i), {31'd0, req_if.req_ready}, 32'd0);
      check($sformatf("v%0d_aw_count", i), aw_hs - a0, vt[i].bus ? 1 : 0);
      check($sformatf("v%0d_w_count", i), w_hs - w0, vt[i].bus ? 1 : 0);
      if (vt[i].bus) begin
        check($sformatf("v%0d_awaddr", i), cap_awaddr, vt[i].awaddr);
        check($sformatf("v%0d_wdata", i), cap_wdata, vt[i].wdata);
        check($sformatf("v%0d_wstrb", i), {28'd0, cap_wstrb}, {28'd0, vt[i].wstrb});
      end
      ack_resp();
      check($sformatf("v%0d_req_ready_after", i), {31'd0, req_if.req_ready}, 32'd1);
      check($sformatf("v%0d_resp_valid_after", i), {31'd0, req_if.resp_valid}, 32'd0);
    end

    // ---- sw with W delayed to cycle 4 ----
    cfg_aw_dly = 0; cfg_w_dly = 3; cfg_b_dly = 0; cfg_bresp = 2'b00;
    send_req(32'h8000_0010, 32'h5A5A_A5A5, 2'd2);
    for (int c = 1; c <= 5; c++) begin
      check($sformatf("slowW_c%0d_awvalid", c), {31'd0, axi_if.awvalid}, (c == 1) ? 1 : 0);
      check($sformatf("slowW_c%0d_wvalid", c), {31'd0, axi_if.wvalid}, (c <= 4) ? 1 : 0);
      check($sformatf("slowW_c%0d_bready", c), {31'd0, axi_if.bready}, (c == 5) ? 1 : 0);
      if (c <= 4) begin
        check($sformatf("slowW_c%0d_awaddr", c), axi_if.awaddr, 32'h8000_0010);
        check($sformatf("slowW_c%0d_wdata", c), axi_if.wdata, 32'h5A5A_A5A5);
        check($sformatf("slowW_c%0d_wstrb", c), {28'd0, axi_if.wstrb}, 32'hF);
      end
      @(negedge clk);
    end
    check("slowW_resp_valid", {31'd0, req_if.resp_valid}, 32'd1);
    check("slowW_resp_code", {30'd0, req_if.resp_code}, 32'd0);
    ack_resp();

    // ---- timeout: slave never returns B, TIMEOUT=8 ----
    to_req_if.req_valid = 1'b1; to_req_if.req_addr = 32'h8000_0020;
    to_req_if.req_data = 32'h0BAD_F00D; to_req_if.req_size = 2'd2;
    @(negedge clk);
    to_req_if.req_valid = 1'b0;
    lat = 1;
    while (!to_req_if.resp_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("tmo_latency", lat, 9);
    check("tmo_resp_valid", {31'd0, to_req_if.resp_valid}, 32'd1);
    check("tmo_resp_code", {30'd0, to_req_if.resp_code}, 32'd3);
    check("tmo_resp_err", {31'd0, to_req_if.resp_err}, 32'd1);
    check("tmo_awvalid", {31'd0, to_axi_if.awvalid}, 32'd0);
    check("tmo_wvalid", {31'd0, to_axi_if.wvalid}, 32'd0);
    check("tmo_bready", {31'd0, to_axi_if.bready}, 32'd0);
    to_req_if.resp_ready = 1'b1;
    @(negedge clk);
    to_req_if.resp_ready = 1'b0;
    check("tmo_req_ready_after", {31'd0, to_req_if.req_ready}, 32'd1);

    // ---- reset while waiting for B ----
    cfg_w_dly = 0; cfg_b_dly = 5;
    send_req(32'h8000_0030, 32'h1111_2222, 2'd2);
    @(negedge clk);
    check("rstmid_bready_before", {31'd0, axi_if.bready}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_req_ready", {31'd0, req_if.req_ready}, 32'd1);
    check("rstmid_bready", {31'd0, axi_if.bready}, 32'd0);
    check("rstmid_resp_valid", {31'd0, req_if.resp_valid}, 32'd0);
    check("rstmid_awvalid", {31'd0, axi_if.awvalid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    cfg_b_dly = 0;
    @(negedge clk);
    a0 = aw_hs;
    send_req(32'h8000_0040, 32'h3333_4444, 2'd2);
    wait_resp(lat);
    check("rstmid_new_code", {30'd0, req_if.resp_code}, 32'd0);
    check("rstmid_new_latency", lat, 3);
    check("rstmid_new_wdata", cap_wdata, 32'h3333_4444);
    check("rstmid_new_aw_count", aw_hs - a0, 1);
    ack_resp();

    // ---- response held off for 5 cycles ----
    cfg_bresp = 2'b10;
    send_req(32'h8000_0050, 32'h7777_8888, 2'd2);
    wait_resp(lat);
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hold_k%0d_resp_valid", k), {31'd0, req_if.resp_valid}, 32'd1);
      check($sformatf("hold_k%0d_resp_code", k), {30'd0, req_if.resp_code}, 32'd2);
      check($sformatf("hold_k%0d_resp_err", k), {31'd0, req_if.resp_err}, 32'd1);
      check($sformatf("hold_k%0d_req_ready", k), {31'd0, req_if.req_ready}, 32'd0);
      @(negedge clk);
    end
    ack_resp();
    check("hold_req_ready_after", {31'd0, req_if.req_ready}, 32'd1);

    // ---- randomized stores against the reference model ----
    for (int n = 0; n < 40; n++) begin
      rs = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
      rd = $urandom;
      rb = 2'($urandom_range(0, 3));
      cfg_aw_dly = $urandom_range(0, 3);
      cfg_w_dly  = $urandom_range(0, 3);
      cfg_b_dly  = $urandom_range(0, 3);
      cfg_bresp  = rb;
      ref_store(ra, rd, rs, legal, ea, ew, es);
      ecode = !legal ? 2'd1 : (rb >= 2'd2 ? 2'd2 : 2'd0);
      a0 = aw_hs; w0 = w_hs;
      send_req(ra, rd, rs);
      wait_resp(lat);
      check($sformatf("rnd%0d_code", n), {30'd0, req_if.resp_code}, {30'd0, ecode});
      check($sformatf("rnd%0d_err", n), {31'd0, req_if.resp_err}, (ecode != 2'd0) ? 1 : 0);
      check($sformatf("rnd%0d_aw_count", n), aw_hs - a0, legal ? 1 : 0);
      check($sformatf("rnd%0d_w_count", n), w_hs - w0, legal ? 1 : 0);
      if (legal) begin
        check($sformatf("rnd%0d_awaddr", n), cap_awaddr, ea);
        check($sformatf("rnd%0d_wdata", n), cap_wdata, ew);
        check($sformatf("rnd%0d_wstrb", n), {28'd0, cap_wstrb}, {28'd0, es});
      end
      ack_resp();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
